mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Single-port main-memory arbiter directly downstream of the I-cache, the D-cache and the next-line prefetcher.
- Grants one 256-bit cacheline transaction at a time to the physical memory / cacheline adaptor and returns data and response to the winning requestor.
- Merges a demand I-cache miss onto an in-flight prefetch of the same line.
- Guards the prefetcher against starvation.

Parameters:
- PF_MAX_WAIT, 16, cycles a pending prefetch may lose arbitration before it is forced to highest priority once.
- OFFSET_BITS, 5, line-offset bits ignored in address compares (32-byte lines).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  32  I-cache line address
- i_rdata  out  256  I-cache read data
- i_resp  out  1  I-cache completion pulse
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache writeback request, held until d_resp
- d_address  in  32  D-cache line address
- d_wdata  in  256  D-cache writeback data
- d_rdata  out  256  D-cache read data
- d_resp  out  1  D-cache completion pulse
- pf_read  in  1  prefetch read request, held until pf_resp
- pf_address  in  32  prefetch line address
- pf_rdata  out  256  prefetch read data
- pf_resp  out  1  prefetch completion pulse
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_address  out  32  memory line address
- mem_wdata  out  256  memory write data
- mem_rdata  in  256  memory read data
- mem_resp  in  1  memory completion pulse

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, grant NONE.
  - pf_wait counter 0, force flag 0.
- States:
  - IDLE: evaluate requests.
  - BUSY: one transaction outstanding.
  - DONE: one-cycle turnaround.
- Priority in IDLE:
  - D (write or read) > I > PF.
  - Exception: if force flag = 1 and pf_read = 1, PF wins.
  - d_write and d_read both high: treat as write.
- Grant, IDLE -> BUSY on the edge where any request is seen:
  - Latch grant, mem_address, mem_wdata.
  - Assert mem_read or mem_write from that edge.
  - Latency: request visible in cycle t, mem command high in cycle t+1.
- BUSY:
  - mem_* held constant; request inputs may change without effect on mem_*.
  - mem_rdata/mem_resp routed combinationally: x_rdata = mem_rdata and x_resp = mem_resp only for the granted requestor. All other x_resp are 0.
  - x_rdata of non-granted requestors holds its last value.
- Merge:
  - Applies while grant = PF and i_read = 1 with i_address[31:OFFSET_BITS] == latched address[31:OFFSET_BITS].
  - On mem_resp: i_resp and pf_resp both pulse and i_rdata = pf_rdata = mem_rdata.
  - The compare is evaluated in the mem_resp cycle.
- On mem_resp: mem_read/mem_write deassert on the next edge; BUSY -> DONE.
- DONE:
  - No grants, no resp.
  - Allows requestors to drop their request one cycle after resp.
  - DONE -> IDLE unconditionally.
  - Minimum back-to-back spacing: mem_resp at t, next mem command at t+3 earliest.
- Starvation guard:
  - pf_wait increments (saturating at PF_MAX_WAIT) each IDLE cycle in which pf_read = 1 and PF loses.
  - When pf_wait == PF_MAX_WAIT, force flag sets.
  - Both clear when PF is granted or when pf_read = 0.
- Write path: d_write grant sets mem_write; d_resp pulses on mem_resp; d_rdata unchanged.
- mem_resp in IDLE or DONE: ignored, no x_resp.
- rst mid-transaction: returns to IDLE with all commands deasserted. The outstanding memory response is dropped (memory model is also reset).

Decomposition:
- Shared package `arb_pkg`:
  - enum `arb_grant_t {GRANT_NONE, GRANT_I, GRANT_D, GRANT_PF}`
  - enum `arb_state_t {ARB_IDLE, ARB_BUSY, ARB_DONE}`
  - `LINE_BITS = 256`
- Sub-module `arb_pf_guard`: pf_wait counter and force flag, with inputs pf_read, pf_lost, pf_granted and output force.
- FSM, latching and muxing stay in mem_arbiter.

Test Plan:
- Lone I read of 0x0000_1000; memory responds 5 cycles later with data A.
  - Response: mem_read high cycle t+1 with mem_address 0x0000_1000.
  - i_resp pulses 1 cycle with i_rdata = A.
  - d_resp and pf_resp stay 0.
  - mem_read low the cycle after.
- d_write 0x0000_2000 and i_read 0x0000_3000 raised in the same cycle.
  - Response: write granted first (mem_write, mem_wdata = d_wdata).
  - After d_resp and DONE, I read issued at earliest mem_resp + 3.
- PF read 0x0000_1020 in flight; i_read 0x0000_1024 raised mid-transaction.
  - Response: single mem_read; on mem_resp both i_resp and pf_resp pulse with identical data.
  - No second memory transaction.
- PF starvation: pf_read held while I/D alternate continuously, PF_MAX_WAIT = 4.
  - Response: PF granted by the 5th IDLE arbitration after it first loses, despite a pending D request.
- rst asserted during BUSY.
  - Response: next cycle all outputs 0, state IDLE.
  - A late mem_resp produces no x_resp.
  - A new i_read is serviced normally.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the main-memory arbiter: grant owner, FSM state and line width.
package arb_pkg;

    localparam int LINE_BITS = 256;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_I,
        GRANT_D,
        GRANT_PF
    } arb_grant_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

endpackage

// File: rtl/arb_pf_guard.sv
// Prefetch starvation guard: counts lost IDLE arbitrations and raises a one-shot
// force flag once the prefetcher has waited PF_MAX_WAIT times.
module arb_pf_guard #(
    parameter int PF_MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pf_read_i,
    input  logic pf_lost_i,
    input  logic pf_granted_i,
    output logic pf_force_o
);

    localparam int CW = $clog2(PF_MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(PF_MAX_WAIT);

    logic [CW-1:0] pf_wait_q, pf_wait_d;
    logic          force_q, force_d;

    always_comb begin
        pf_wait_d = pf_wait_q;
        force_d   = force_q;
        if (!pf_read_i || pf_granted_i) begin
            pf_wait_d = '0;
            force_d   = 1'b0;
        end else begin
            if (pf_lost_i && (pf_wait_q != WAIT_MAX)) begin
                pf_wait_d = pf_wait_q + 1'b1;
            end
            // Flag rises on the same edge the count saturates so the very next arbitration is forced.
            if (pf_wait_d == WAIT_MAX) begin
                force_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pf_wait_q <= '0;
            force_q   <= 1'b0;
        end else begin
            pf_wait_q <= pf_wait_d;
            force_q   <= force_d;
        end
    end

    assign pf_force_o = force_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port cacheline arbiter between I-cache, D-cache and next-line prefetcher,
// with demand-I merge onto an in-flight prefetch of the same line.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int PF_MAX_WAIT = 16,
    parameter int OFFSET_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_read,
    input  logic [31:0]          i_address,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_resp,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [31:0]          d_address,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_resp,
    input  logic                 pf_read,
    input  logic [31:0]          pf_address,
    output logic [LINE_BITS-1:0] pf_rdata,
    output logic                 pf_resp,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_address,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_resp
);

    arb_state_t           state_q, state_d;
    arb_grant_t           grant_q, grant_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [31:0]          mem_address_q, mem_address_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_BITS-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_BITS-1:0] d_rdata_q, d_rdata_d;
    logic [LINE_BITS-1:0] pf_rdata_q, pf_rdata_d;

    arb_grant_t  win;
    logic        win_write;
    logic [31:0] win_address;
    logic        in_idle, busy;
    logic        pf_force, pf_lost, pf_granted;
    logic        merge, i_sel, d_sel, pf_sel;

    assign in_idle = (state_q == ARB_IDLE);
    assign busy    = (state_q == ARB_BUSY);

    always_comb begin
        win         = GRANT_NONE;
        win_write   = 1'b0;
        win_address = '0;
        if (pf_force && pf_read) begin
            win         = GRANT_PF;
            win_address = pf_address;
        end else if (d_write || d_read) begin
            win         = GRANT_D;
            win_write   = d_write;
            win_address = d_address;
        end else if (i_read) begin
            win         = GRANT_I;
            win_address = i_address;
        end else if (pf_read) begin
            win         = GRANT_PF;
            win_address = pf_address;
        end
    end

    assign pf_lost    = in_idle && pf_read && (win != GRANT_PF);
    assign pf_granted = in_idle && (win == GRANT_PF);

    arb_pf_guard #(
        .PF_MAX_WAIT (PF_MAX_WAIT)
    ) u_guard (
        .clk          (clk),
        .rst          (rst),
        .pf_read_i    (pf_read),
        .pf_lost_i    (pf_lost),
        .pf_granted_i (pf_granted),
        .pf_force_o   (pf_force)
    );

    // A demand I miss rides on the prefetch when it targets the same line at response time.
    assign merge  = busy && (grant_q == GRANT_PF) && i_read
                    && (i_address[31:OFFSET_BITS] == mem_address_q[31:OFFSET_BITS]);
    assign i_sel  = busy && ((grant_q == GRANT_I) || merge);
    assign d_sel  = busy && (grant_q == GRANT_D) && !mem_write_q;
    assign pf_sel = busy && (grant_q == GRANT_PF);

    assign i_resp   = i_sel && mem_resp;
    assign d_resp   = busy && (grant_q == GRANT_D) && mem_resp;
    assign pf_resp  = pf_sel && mem_resp;
    assign i_rdata  = i_sel  ? mem_rdata : i_rdata_q;
    assign d_rdata  = d_sel  ? mem_rdata : d_rdata_q;
    assign pf_rdata = pf_sel ? mem_rdata : pf_rdata_q;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        i_rdata_d     = i_rdata;
        d_rdata_d     = d_rdata;
        pf_rdata_d    = pf_rdata;
        case (state_q)
            ARB_IDLE: begin
                if (win != GRANT_NONE) begin
                    state_d       = ARB_BUSY;
                    grant_d       = win;
                    mem_read_d    = !win_write;
                    mem_write_d   = win_write;
                    mem_address_d = win_address;
                    if (win_write) begin
                        mem_wdata_d = d_wdata;
                    end
                end
            end
            ARB_BUSY: begin
                if (mem_resp) begin
                    state_d     = ARB_DONE;
                    grant_d     = GRANT_NONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            grant_q       <= GRANT_NONE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            pf_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            pf_rdata_q    <= pf_rdata_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
